// File: rtl/lru_matrix_mem.sv
// lru_matrix_mem
//   Responder side of the LRU matrix interface. Holds one LRU matrix vector
//   per cache set and serves the LRU engine's read and update traffic with a
//   registered read, a write, and write-first forwarding. After reset, and on
//   a clear request, every set is swept to INIT_VEC before ready_o rises.
//
// Ports
//   clk_i    clock
//   rst_i    asynchronous active-high reset
//   addr_i   set address for read/write
//   data_i   write data (updated matrix vector)
//   we_i     write enable
//   en_i     port enable; an access happens only when high
//   clear_i  single-cycle request to re-run the init sweep
//   data_o   registered read data (matrix_vec to the LRU engine)
//   ready_o  storage initialised, accesses accepted
//   busy_o   init sweep in progress (~ready_o)
module lru_matrix_mem #(
  parameter int unsigned                SET_BITS     = 2,
  parameter int unsigned                MATRIX_WIDTH = 16,
  parameter logic [MATRIX_WIDTH-1:0]    INIT_VEC     = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [SET_BITS-1:0]     addr_i,
  input  logic [MATRIX_WIDTH-1:0] data_i,
  input  logic                    we_i,
  input  logic                    en_i,
  input  logic                    clear_i,
  output logic [MATRIX_WIDTH-1:0] data_o,
  output logic                    ready_o,
  output logic                    busy_o
);

  localparam int unsigned DEPTH = 1 << SET_BITS;
  localparam logic [SET_BITS:0] CNT_ONE = {{SET_BITS{1'b0}}, 1'b1};

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_e;

  state_e                  state_q, state_d;
  logic [SET_BITS:0]       cnt_q, cnt_d;
  logic [MATRIX_WIDTH-1:0] data_q, data_d;
  logic                    ready_q, ready_d;

  // Single write port shared between the sweep and external accesses.
  logic                    mem_we;
  logic [SET_BITS-1:0]     mem_addr;
  logic [MATRIX_WIDTH-1:0] mem_wdata;

  logic [MATRIX_WIDTH-1:0] mem [DEPTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    ready_d   = ready_q;
    mem_we    = 1'b0;
    mem_addr  = addr_i;
    mem_wdata = data_i;

    unique case (state_q)
      ST_INIT: begin
        data_d  = '0;
        ready_d = 1'b0;
        if (clear_i) begin
          cnt_d = '0;
        end else if (cnt_q[SET_BITS]) begin
          // Counter has passed the last entry: all sets written, open up.
          state_d = ST_READY;
          ready_d = 1'b1;
        end else begin
          mem_we    = 1'b1;
          mem_addr  = cnt_q[SET_BITS-1:0];
          mem_wdata = INIT_VEC;
          cnt_d     = cnt_q + CNT_ONE;
        end
      end

      ST_READY: begin
        if (clear_i) begin
          // Clear wins over any access presented in the same cycle.
          state_d = ST_INIT;
          cnt_d   = '0;
          ready_d = 1'b0;
          data_d  = '0;
        end else if (en_i) begin
          if (we_i) begin
            mem_we = 1'b1;
            data_d = data_i;
          end else begin
            data_d = mem[addr_i];
          end
        end
      end

      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
        ready_d = 1'b0;
        data_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end

  // Storage is not reset; the sweep defines its contents.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign data_o  = data_q;
  assign ready_o = ready_q;
  assign busy_o  = ~ready_q;

endmodule
